// File: rtl/n_term_edge_probe.sv
// North-edge capture probe: snapshots a pre/post-trigger window of the
// terminated north wires and streams it out oldest-first over valid/ready.
module n_term_edge_probe #(
    parameter  int WIDTH = 52,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             UserCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] wire_in,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [AW:0]      post_trig,
    input  logic             arm,
    input  logic             abort,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             triggered,
    output logic [AW-1:0]    trig_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_READ
    } state_t;

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] POSTMAX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sample;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic [AW:0]      r_remaining;
    logic [AW:0]      r_post;
    logic [AW:0]      r_count;
    logic [AW-1:0]    r_trig_idx;
    logic             r_trig;

    logic             w_match;
    logic             w_write;
    logic             w_accept;
    logic             w_enter_read;
    logic [AW-1:0]    w_wr_ptr_nx;
    logic [AW:0]      w_fill_nx;
    logic [AW:0]      w_post_eff;

    assign w_match     = ((r_sample ^ trig_value) & trig_mask) == '0;
    assign w_write     = !abort && (r_state == S_ARMED || r_state == S_POST);
    assign w_accept    = rd_valid && rd_ready;
    assign w_wr_ptr_nx = r_wr_ptr + AW'(1);
    assign w_fill_nx   = (r_fill == FULL) ? r_fill : r_fill + ONE;
    assign w_post_eff  = (post_trig > POSTMAX) ? POSTMAX : post_trig;
    assign w_enter_read = (w_next == S_READ) && (r_state != S_READ);

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (arm) w_next = S_ARMED;
                S_ARMED: if (w_match) w_next = (r_post == '0) ? S_READ : S_POST;
                S_POST:  if (r_remaining == ONE) w_next = S_READ;
                S_READ:  if (w_accept && rd_last) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        rd_valid   = (r_state == S_READ);
        rd_last    = rd_valid && (r_count == ONE);
        rd_data    = r_mem[r_rd_ptr];
        triggered  = r_trig;
        trig_index = r_trig_idx;
    end

    // Buffer is deliberately left out of reset.
    always_ff @(posedge UserCLK) begin
        if (w_write) r_mem[r_wr_ptr] <= r_sample;
    end

    always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
            r_sample    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_remaining <= '0;
            r_post      <= '0;
            r_count     <= '0;
            r_trig_idx  <= '0;
            r_trig      <= 1'b0;
        end else begin
            r_sample <= wire_in;
            if (abort) begin
                r_trig <= 1'b0;
            end else begin
                if (r_state == S_IDLE && arm) begin
                    r_wr_ptr <= '0;
                    r_fill   <= '0;
                    r_trig   <= 1'b0;
                    r_post   <= w_post_eff;
                end
                if (w_write) begin
                    r_wr_ptr <= w_wr_ptr_nx;
                    r_fill   <= w_fill_nx;
                end
                if (r_state == S_ARMED && w_match) begin
                    r_trig      <= 1'b1;
                    r_remaining <= r_post;
                end
                if (r_state == S_POST) r_remaining <= r_remaining - ONE;
                // Oldest entry sits at wr_ptr once the ring has wrapped.
                if (w_enter_read) begin
                    r_rd_ptr   <= (w_fill_nx == FULL) ? w_wr_ptr_nx : '0;
                    r_count    <= w_fill_nx;
                    r_trig_idx <= AW'(w_fill_nx - ONE - r_post);
                end else if (w_accept) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_count  <= r_count - ONE;
                end
            end
        end
    end

endmodule
